mem_arbiter: RTL

//  Shares the single data-memory port between instruction fetch (IFU) and load/store (LSU, fed by exu_mem).

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 41 ++++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the memory-port arbiter.
// State and owner encodings are kept here so the top and the picker agree on them.
package mem_arbiter_pkg;

    localparam int ISA_WIDTH = 32;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_REQ  = 2'd1,
        MA_WAIT = 2'd2
    } ma_state_e;

    typedef enum logic {
        MA_OWN_IFU = 1'b0,
        MA_OWN_LSU = 1'b1
    } ma_owner_e;

    function automatic int streak_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and load/store, plus the LSU streak counter.
// LSU normally wins; after STARVE_LIMIT back-to-back LSU wins over a waiting IFU, the IFU gets one grant.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ifu_req,
    input  logic lsu_req,
    output logic ifu_gnt,
    output logic lsu_gnt
);

    localparam int SW = streak_width(STARVE_LIMIT);

    logic [SW-1:0] streak;
    logic          at_limit;
    logic          ifu_win;

    always_comb begin
        at_limit = (streak == SW'(STARVE_LIMIT));
        ifu_win  = ifu_req && (!lsu_req || at_limit);
        ifu_gnt  = en && ifu_win;
        lsu_gnt  = en && lsu_req && !ifu_win;
    end

    // Only LSU wins that actually delay a waiting IFU count toward the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (ifu_gnt) begin
            streak <= '0;
        end else if (lsu_gnt && ifu_req && !at_limit) begin
            streak <= streak + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: grant, latch the request, run the
// req/ready/rvalid handshake and route the registered response back to its owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ISA_WIDTH,
    parameter int DATA_W       = ISA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_gnt,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_gnt,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    ma_state_e           state_q, state_d;
    ma_owner_e           owner_q;
    logic                rst_d;
    logic                blank;
    logic                grant_en;
    logic                pick_ifu, pick_lsu;
    logic                resp_fire;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W/8-1:0] lat_wmask;
    logic                ifu_rvalid_q, lsu_rvalid_q;
    logic [DATA_W-1:0]   ifu_rdata_q, lsu_rdata_q;

    // Outputs stay quiet during reset and for one cycle after it.
    assign blank    = rst | rst_d;
    assign grant_en = (state_q == MA_IDLE) && !blank;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk     (clk),
        .rst     (rst),
        .en      (grant_en),
        .ifu_req (ifu_req),
        .lsu_req (lsu_req),
        .ifu_gnt (pick_ifu),
        .lsu_gnt (pick_lsu)
    );

    always_comb begin
        state_d   = state_q;
        resp_fire = 1'b0;
        case (state_q)
            MA_IDLE: begin
                if (pick_ifu || pick_lsu) state_d = MA_REQ;
            end
            MA_REQ: begin
                if (mem_ready) begin
                    if (mem_rvalid) begin
                        state_d   = MA_IDLE;
                        resp_fire = 1'b1;
                    end else begin
                        state_d = MA_WAIT;
                    end
                end
            end
            MA_WAIT: begin
                if (mem_rvalid) begin
                    state_d   = MA_IDLE;
                    resp_fire = 1'b1;
                end
            end
            default: state_d = MA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        rst_d <= rst;
        if (rst) begin
            state_q      <= MA_IDLE;
            owner_q      <= MA_OWN_IFU;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_wmask    <= '0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            ifu_rvalid_q <= resp_fire && (owner_q == MA_OWN_IFU);
            lsu_rvalid_q <= resp_fire && (owner_q == MA_OWN_LSU);
            if (resp_fire && owner_q == MA_OWN_IFU) ifu_rdata_q <= mem_rdata;
            if (resp_fire && owner_q == MA_OWN_LSU) lsu_rdata_q <= mem_rdata;
            if (pick_lsu) begin
                owner_q   <= MA_OWN_LSU;
                lat_we    <= lsu_we;
                lat_addr  <= lsu_addr;
                lat_wdata <= lsu_wdata;
                lat_wmask <= lsu_wmask;
            end else if (pick_ifu) begin
                owner_q   <= MA_OWN_IFU;
                lat_we    <= 1'b0;
                lat_addr  <= ifu_addr;
                lat_wdata <= '0;
                lat_wmask <= '0;
            end
        end
    end

    always_comb begin
        ifu_gnt    = pick_ifu;
        lsu_gnt    = pick_lsu;
        mem_req    = !blank && (state_q == MA_REQ);
        mem_we     = blank ? 1'b0 : lat_we;
        mem_addr   = blank ? '0 : lat_addr;
        mem_wdata  = blank ? '0 : lat_wdata;
        mem_wmask  = blank ? '0 : lat_wmask;
        ifu_rvalid = !blank && ifu_rvalid_q;
        lsu_rvalid = !blank && lsu_rvalid_q;
        ifu_rdata  = blank ? '0 : ifu_rdata_q;
        lsu_rdata  = blank ? '0 : lsu_rdata_q;
    end

endmodule
